offchip_sram_req_sequencer: RTL and testbench



---
 rtl/offchip_sram_seq_pkg.sv | 30 +++
 rtl/offchip_sram_phase_counter.sv | 29 ++
 rtl/offchip_sram_req_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_offchip_sram_req_sequencer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/offchip_sram_seq_pkg.sv
// Shared types and constants for the off-chip SRAM request sequencer.
package offchip_sram_seq_pkg;

    localparam int          PHASE_CNT_W       = 4;
    localparam logic [31:0] DEFAULT_PARK_ADDR = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        W_PULSE,
        W_HOLD,
        R_WAIT,
        R_CAPTURE,
        RESP
    } seq_state_t;

    // Request fields held for the whole access.
    typedef struct packed {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  byte_en;
    } seq_req_t;

    // Narrow a cycle-count parameter to the phase counter width.
    function automatic logic [PHASE_CNT_W-1:0] phase_len(input int unsigned cycles);
        return PHASE_CNT_W'(cycles);
    endfunction

endpackage

// File: rtl/offchip_sram_phase_counter.sv
// Loadable down-counter timing one phase of an SRAM access.
// "expired" flags the last cycle of the phase (count == 1).
module offchip_sram_phase_counter
    import offchip_sram_seq_pkg::*;
(
    input  logic                   clk,
    input  logic                   nRST,
    input  logic                   load,
    input  logic [PHASE_CNT_W-1:0] load_val,
    input  logic                   dec,
    output logic [PHASE_CNT_W-1:0] count,
    output logic                   expired
);

    // Load has priority; decrement saturates at zero.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == PHASE_CNT_W'(1));

endmodule

// File: rtl/offchip_sram_req_sequencer.sv
// Request-side timing sequencer in front of the off-chip SRAM controller.
// Generates address setup, write-enable pulse and hold timing, captures read
// data and returns a single-cycle response per accepted request.
module offchip_sram_req_sequencer
    import offchip_sram_seq_pkg::*;
#(
    parameter int unsigned SETUP_CYCLES    = 1,
    parameter int unsigned WE_PULSE_CYCLES = 2,
    parameter int unsigned HOLD_CYCLES     = 1,
    parameter int unsigned READ_CYCLES     = 2,
    parameter logic [31:0] PARK_ADDR       = DEFAULT_PARK_ADDR
)
(
    input  logic        clk,
    input  logic        nRST,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_byte_en,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_wen,
    output logic [3:0]  mem_byte_en,
    input  logic [31:0] mem_rdata,
    input  logic        mem_wait,
    input  logic        mem_active
);

    localparam logic [PHASE_CNT_W-1:0] SETUP_LEN = phase_len(SETUP_CYCLES);
    localparam logic [PHASE_CNT_W-1:0] PULSE_LEN = phase_len(WE_PULSE_CYCLES);
    localparam logic [PHASE_CNT_W-1:0] HOLD_LEN  = phase_len(HOLD_CYCLES);
    localparam logic [PHASE_CNT_W-1:0] READ_LEN  = phase_len(READ_CYCLES);

    seq_state_t             state, state_nxt;
    seq_req_t               req_q;
    logic                   req_accept;
    logic                   cnt_load, cnt_dec, cnt_expired;
    logic [PHASE_CNT_W-1:0] cnt_load_val;
    logic [PHASE_CNT_W-1:0] cnt_value;
    logic                   rsp_upd;
    logic                   rsp_err_nxt;
    logic [31:0]            rsp_rdata_nxt;

    // Ready is forced low while reset is asserted, not just after it.
    assign req_ready  = nRST && (state == IDLE);
    assign req_accept = req_valid && req_ready;

    offchip_sram_phase_counter u_phase_cnt (
        .clk      (clk),
        .nRST     (nRST),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .count    (cnt_value),
        .expired  (cnt_expired)
    );

    // State register.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, phase counter control and response update.
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    always_comb begin
        state_nxt     = state;
        cnt_load      = 1'b0;
        cnt_load_val  = '0;
        cnt_dec       = 1'b0;
        rsp_upd       = 1'b0;
        rsp_err_nxt   = 1'b0;
        rsp_rdata_nxt = '0;
        case (state)
            IDLE: begin
                if (req_accept) begin
                    state_nxt    = SETUP;
                    cnt_load     = 1'b1;
                    cnt_load_val = SETUP_LEN;
                end
            end
            SETUP: begin
                if (!cnt_expired) begin
                    cnt_dec = 1'b1;
                end else if (!mem_active) begin
                    state_nxt   = RESP;
                    rsp_upd     = 1'b1;
                    rsp_err_nxt = 1'b1;
                end else if (req_q.wen) begin
                    state_nxt    = W_PULSE;
                    cnt_load     = 1'b1;
                    cnt_load_val = PULSE_LEN;
                end else begin
                    state_nxt    = R_WAIT;
                    cnt_load     = 1'b1;
                    cnt_load_val = READ_LEN;
                end
            end
            W_PULSE: begin
                // mem_wait freezes the count, stretching the pulse cycle-for-cycle.
                if (!mem_wait) begin
                    if (cnt_expired) begin
                        state_nxt    = W_HOLD;
                        cnt_load     = 1'b1;
                        cnt_load_val = HOLD_LEN;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
            end
            W_HOLD: begin
                if (cnt_expired) begin
                    state_nxt = RESP;
                    rsp_upd   = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            R_WAIT: begin
                if (!mem_wait) begin
                    if (cnt_expired) begin
                        state_nxt = R_CAPTURE;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
            end
            R_CAPTURE: begin
                state_nxt     = RESP;
                rsp_upd       = 1'b1;
                rsp_rdata_nxt = mem_rdata;
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Latch the request on accept; it drives the SRAM pins for the whole access.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            req_q <= '0;
        end else if (req_accept) begin
            req_q <= '{wen: req_wen, addr: req_addr, wdata: req_wdata, byte_en: req_byte_en};
        end
    end

    // Response payload, held until the next response is produced.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (rsp_upd) begin
            rsp_rdata <= rsp_rdata_nxt;
            rsp_err   <= rsp_err_nxt;
        end
    end

    // Pin outputs decoded from state; the address parks outside the SRAM window when idle.
    always_comb begin
        mem_addr    = req_q.addr;
        mem_wdata   = req_q.wdata;
        mem_byte_en = req_q.byte_en;
        mem_wen     = (state == W_PULSE);
        rsp_valid   = (state == RESP);
        if ((state == IDLE) || (state == RESP)) begin
            mem_addr = PARK_ADDR;
        end
    end

endmodule

// File: tb/tb_offchip_sram_req_sequencer.sv
// Self-checking bench for offchip_sram_req_sequencer with a byte-lane SRAM
// model (window 0x8000..0xFFFF) and a response scoreboard.
module tb_offchip_sram_req_sequencer;

    localparam logic [31:0] PARK = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        nRST = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wen = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_byte_en = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_wen;
    logic [3:0]  mem_byte_en;
    logic [31:0] mem_rdata = '0;
    logic        mem_wait = 1'b0;
    logic        mem_active;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;
    exp_t sb[$];

    logic [31:0] sram [int];

    offchip_sram_req_sequencer dut (
        .clk         (clk),
        .nRST        (nRST),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_wen     (req_wen),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_byte_en (req_byte_en),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_wen     (mem_wen),
        .mem_byte_en (mem_byte_en),
        .mem_rdata   (mem_rdata),
        .mem_wait    (mem_wait),
        .mem_active  (mem_active)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM controller model: combinational window decode, byte-lane writes, registered read.
    assign mem_active = (mem_addr[31:16] == 16'h0000) && mem_addr[15];

    always @(posedge clk) begin
        logic [31:0] word;
        int          key;
        key  = int'(mem_addr[31:2]);
        word = sram.exists(key) ? sram[key] : 32'h0;
        if (mem_wen && mem_active) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_byte_en[b]) word[8*b +: 8] = mem_wdata[8*b +: 8];
            end
            sram[key] = word;
        end
        mem_rdata <= word;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Drive one request, wait (bounded) for acceptance, push the expected response.
    task automatic send(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input logic [31:0] exp_rdata,
                        input logic exp_err, input int lat);
        int waited;
        @(negedge clk);
        req_valid   = 1'b1;
        req_wen     = wen;
        req_addr    = addr;
        req_wdata   = wdata;
        req_byte_en = be;
        waited = 0;
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 20) check("accept_timeout", 32'(waited), 32'd0);
        @(posedge clk);
        #1;
        sb.push_back('{rdata: exp_rdata, err: exp_err, due: cyc + lat - 1});
        req_valid = 1'b0;
    endtask

    // Sample n cycles starting at the current cycle; mem_wait high for cycle indices [wf, wt).
    task automatic trace(input int n, input int wf, input int wt, input logic [31:0] a,
                         output logic [15:0] wen_tr, output logic [15:0] rdy_tr,
                         output logic [15:0] park_tr, output logic [15:0] aeq_tr);
        wen_tr = '0; rdy_tr = '0; park_tr = '0; aeq_tr = '0;
        for (int i = 0; i < n; i++) begin
            mem_wait = (i >= wf) && (i < wt);
            @(negedge clk);
            wen_tr[i]  = mem_wen;
            rdy_tr[i]  = req_ready;
            park_tr[i] = (mem_addr == PARK);
            aeq_tr[i]  = (mem_addr == a);
            @(posedge clk);
            #1;
        end
        mem_wait = 1'b0;
    endtask

    task automatic drain();
        int waited = 0;
        while (sb.size() != 0 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (sb.size() != 0) check("drain_timeout", 32'(sb.size()), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        logic [15:0] wen_tr, rdy_tr, park_tr, aeq_tr;

        // Response monitor: pops the scoreboard on every rsp_valid.
        fork
            forever begin
                @(negedge clk);
                if (rsp_valid) begin
                    if (sb.size() == 0) begin
                        check("rsp_spurious", 32'(rsp_valid), 32'd0);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        check("rsp_rdata", rsp_rdata, e.rdata);
                        check("rsp_err", 32'(rsp_err), 32'(e.err));
                        check("rsp_cycle", 32'(cyc), 32'(e.due));
                    end
                end
            end
        join_none

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_mem_addr", mem_addr, PARK);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_mem_wen", 32'(mem_wen), 32'd0);
        check("rst_mem_byte_en", 32'(mem_byte_en), 32'd0);
        nRST = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(req_ready), 32'd1);

        // Full write: wen t+2..t+3, address stable t+1..t+4, parked in t+5.
        send(1'b1, 32'h0000_9000, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, 5);
        trace(5, 0, 0, 32'h0000_9000, wen_tr, rdy_tr, park_tr, aeq_tr);
        check("wr_wen_trace", 32'(wen_tr[4:0]), 32'b00110);
        check("wr_addr_trace", 32'(aeq_tr[4:0]), 32'b01111);
        check("wr_park_t5", 32'(park_tr[4]), 32'd1);
        drain();

        // Read back, no write strobe.
        send(1'b0, 32'h0000_9000, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, 5);
        trace(5, 0, 0, 32'h0000_9000, wen_tr, rdy_tr, park_tr, aeq_tr);
        check("rd_wen_trace", 32'(wen_tr[4:0]), 32'b00000);
        drain();

        // Partial-lane write then read merges lanes.
        send(1'b1, 32'h0000_9000, 32'h1234_5678, 4'b0011, 32'h0, 1'b0, 5);
        drain();
        send(1'b0, 32'h0000_9000, 32'h0, 4'h0, 32'hDEAD_5678, 1'b0, 5);
        drain();

        // byte_en=0 write runs the full sequence and leaves memory untouched.
        send(1'b1, 32'h0000_9000, 32'hFFFF_FFFF, 4'b0000, 32'h0, 1'b0, 5);
        trace(5, 0, 0, 32'h0000_9000, wen_tr, rdy_tr, park_tr, aeq_tr);
        check("be0_wen_trace", 32'(wen_tr[4:0]), 32'b00110);
        drain();
        send(1'b0, 32'h0000_9000, 32'h0, 4'h0, 32'hDEAD_5678, 1'b0, 5);
        drain();

        // Out-of-window write: error response at t+2, no strobe.
        send(1'b1, 32'h0000_1000, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b1, 2);
        trace(3, 0, 0, 32'h0000_1000, wen_tr, rdy_tr, park_tr, aeq_tr);
        check("oor_wen_trace", 32'(wen_tr[2:0]), 32'b000);
        drain();

        // mem_wait high t+2..t+4 stretches the pulse to t+2..t+6, response t+8.
        send(1'b1, 32'h0000_9004, 32'h0BAD_CAFE, 4'hF, 32'h0, 1'b0, 8);
        trace(8, 1, 4, 32'h0000_9004, wen_tr, rdy_tr, park_tr, aeq_tr);
        check("wait_wen_trace", 32'(wen_tr[7:0]), 32'b0011_1110);
        drain();
        send(1'b0, 32'h0000_9004, 32'h0, 4'h0, 32'h0BAD_CAFE, 1'b0, 5);
        drain();

        // Back-to-back writes with req_valid held: second accepted at the end of t+6.
        send(1'b1, 32'h0000_9010, 32'h1111_1111, 4'hF, 32'h0, 1'b0, 5);
        req_valid   = 1'b1;
        req_wen     = 1'b1;
        req_addr    = 32'h0000_9014;
        req_wdata   = 32'h2222_2222;
        req_byte_en = 4'hF;
        trace(6, 0, 0, 32'h0000_9010, wen_tr, rdy_tr, park_tr, aeq_tr);
        sb.push_back('{rdata: 32'h0, err: 1'b0, due: cyc + 4});
        req_valid = 1'b0;
        check("q_ready_trace", 32'(rdy_tr[5:0]), 32'b100000);
        check("q_park_t5", 32'(park_tr[4]), 32'd1);
        drain();
        send(1'b0, 32'h0000_9014, 32'h0, 4'h0, 32'h2222_2222, 1'b0, 5);
        drain();

        // Reset in the middle of the write pulse: strobe drops without a clock edge.
        send(1'b1, 32'h0000_9008, 32'h5555_AAAA, 4'hF, 32'h0, 1'b0, 5);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("mid_wen_before", 32'(mem_wen), 32'd1);
        #2;
        nRST = 1'b0;
        #1;
        check("mid_wen_after", 32'(mem_wen), 32'd0);
        check("mid_addr_park", mem_addr, PARK);
        check("mid_ready_low", 32'(req_ready), 32'd0);
        void'(sb.pop_back());
        repeat (3) @(negedge clk);
        nRST = 1'b1;
        @(negedge clk);
        check("mid_ready_after", 32'(req_ready), 32'd1);
        send(1'b0, 32'h0000_9000, 32'h0, 4'h0, 32'hDEAD_5678, 1'b0, 5);
        drain();

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
